// File: rtl/dram_dump_reader_pkg.sv
// Shared definitions for the DRAM dump reader: FSM encoding, memory strobe codes
// and default widths.
package dram_dump_reader_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_LAT = 1;
    localparam int LAT_CNT_W  = 3;

    localparam logic [1:0] MEM_RD   = 2'b10;
    localparam logic [1:0] MEM_IDLE = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/dram_dump_reader_rd_lat_counter.sv
// Loadable down-counter that measures the memory read latency while the reader
// sits in WAIT; o_zero marks the cycle on which read data is valid.
module rd_lat_counter
    import dram_dump_reader_pkg::*;
#(
    parameter int W = LAT_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dram_dump_reader.sv
// Streams a block of data-memory words out over a valid/ready port, one read in
// flight at a time, with abort and zero-length dump support.
module dram_dump_reader
    import dram_dump_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_word_count,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [1:0]        o_mem_read_en,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic              r_runEn;
    logic [ADDR_W-1:0] r_memAddr;
    logic [ADDR_W-1:0] r_remaining;
    logic [DATA_W-1:0] r_outData;
    logic              w_latZero;

    // Start is only honoured once this flag has been clocked high after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_runEn <= 1'b0;
        end else begin
            r_runEn <= 1'b1;
        end
    end

    rd_lat_counter #(
        .W(LAT_CNT_W)
    ) u_rdLatCounter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (r_state == S_ISSUE),
        .i_load_val(LAT_LOAD),
        .i_en      (r_state == S_WAIT),
        .o_zero    (w_latZero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort overrides every transition, including a same-cycle handshake.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_runEn && i_start) begin
                    w_nextState = (i_word_count == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE:  w_nextState = S_WAIT;
            S_WAIT: begin
                if (w_latZero) begin
                    w_nextState = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_out_ready) begin
                    w_nextState = (r_remaining == ADDR_W'(1)) ? S_FINISH : S_ISSUE;
                end
            end
            S_FINISH: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
        if (i_abort && (r_state != S_IDLE)) begin
            w_nextState = S_IDLE;
        end
    end

    // The address only moves when another read follows, so it holds after the last word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_memAddr   <= '0;
            r_remaining <= '0;
            r_outData   <= '0;
        end else begin
            if ((r_state == S_IDLE) && (w_nextState == S_ISSUE)) begin
                r_memAddr   <= i_base_addr;
                r_remaining <= i_word_count;
            end
            if ((r_state == S_HOLD) && (w_nextState != S_HOLD) && (w_nextState != S_IDLE)) begin
                r_remaining <= r_remaining - ADDR_W'(1);
                if (w_nextState == S_ISSUE) begin
                    r_memAddr <= r_memAddr + ADDR_W'(1);
                end
            end
            if ((r_state == S_WAIT) && (w_nextState == S_HOLD)) begin
                r_outData <= i_mem_rdata;
            end
        end
    end

    assign o_mem_addr    = r_memAddr;
    assign o_mem_read_en = (r_state == S_ISSUE) ? MEM_RD : MEM_IDLE;
    assign o_out_data    = r_outData;
    assign o_out_valid   = (r_state == S_HOLD);
    assign o_out_last    = (r_state == S_HOLD) && (r_remaining == ADDR_W'(1));
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_FINISH) && !i_abort;

endmodule

// File: tb/tb_dram_dump_reader.sv
// Scoreboard bench for dram_dump_reader: two instances (read latency 1 and 3)
// share stimulus and are checked against a memory-content reference model.
module tb_dram_dump_reader;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } expItem_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          outReady = 1'b0;
    logic [AW-1:0] baseAddr;
    logic [AW-1:0] wordCount;

    logic [AW-1:0] memAddr   [2];
    logic [1:0]    memReadEn [2];
    logic [DW-1:0] memRdata  [2];
    logic [DW-1:0] outData   [2];
    logic          outValid  [2];
    logic          outLast   [2];
    logic          busy      [2];
    logic          done      [2];

    logic [DW-1:0] mem [65536];
    expItem_t      expQ0[$];
    expItem_t      expQ1[$];

    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   readyPct = 100;
    logic pending [2];
    int   doneDue [2];
    int   issueCycle [2];
    logic prevValid [2];
    logic prevDone [2];
    logic prevLast [2];
    logic [DW-1:0] prevData [2];
    logic prevReady = 1'b0;
    logic prevAbort = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    dram_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dutLat1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_base_addr(baseAddr), .i_word_count(wordCount),
        .o_mem_addr(memAddr[0]), .o_mem_read_en(memReadEn[0]), .i_mem_rdata(memRdata[0]),
        .o_out_data(outData[0]), .o_out_valid(outValid[0]), .i_out_ready(outReady),
        .o_out_last(outLast[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    dram_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dutLat3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_base_addr(baseAddr), .i_word_count(wordCount),
        .o_mem_addr(memAddr[1]), .o_mem_read_en(memReadEn[1]), .i_mem_rdata(memRdata[1]),
        .o_out_data(outData[1]), .o_out_valid(outValid[1]), .i_out_ready(outReady),
        .o_out_last(outLast[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    // Memory models: data for a read appears RD_LAT cycles after the strobe, garbage otherwise.
    logic [DW-1:0] pipe0;
    logic [DW-1:0] pipe1 [3];
    always @(posedge clk) begin
        pipe0    <= (memReadEn[0] == 2'b10) ? mem[memAddr[0]] : DW'($urandom);
        pipe1[0] <= (memReadEn[1] == 2'b10) ? mem[memAddr[1]] : DW'($urandom);
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign memRdata[0] = pipe0;
    assign memRdata[1] = pipe1[2];

    always @(posedge clk) begin
        #2;
        outReady = (int'($urandom_range(99)) < readyPct);
    end

    function automatic int latOf(input int l);
        return (l == 0) ? 1 : 3;
    endfunction

    function automatic int qSize(input int l);
        return (l == 0) ? expQ0.size() : expQ1.size();
    endfunction

    function automatic expItem_t qFront(input int l);
        return (l == 0) ? expQ0[0] : expQ1[0];
    endfunction

    function automatic expItem_t qPop(input int l);
        expItem_t e;
        if (l == 0) e = expQ0.pop_front();
        else        e = expQ1.pop_front();
        return e;
    endfunction

    function automatic void qClear(input int l);
        if (l == 0) expQ0.delete();
        else        expQ1.delete();
    endfunction

    task automatic checkOutput(input string name, input int lane,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s lane=%0d actual=%0h expected=%0h t=%0t", name, lane, actual, expected, $time);
        end
    endtask

    // Reference model: a dump of N words from base reads base, base+1, ... modulo 2^16.
    function automatic void pushDump(input logic [AW-1:0] base, input logic [AW-1:0] count);
        expItem_t e;
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < int'(count); i++) begin
                e.addr = base + AW'(i);
                e.data = mem[e.addr];
                e.last = (i == int'(count) - 1);
                if (l == 0) expQ0.push_back(e);
                else        expQ1.push_back(e);
            end
            pending[l] = 1'b1;
            doneDue[l] = 0;
        end
    endfunction

    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW-1:0] count);
        pushDump(base, count);
        start     = 1'b1;
        baseAddr  = base;
        wordCount = count;
        @(posedge clk); #1;
        start     = 1'b0;
        baseAddr  = AW'($urandom);
        wordCount = AW'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy[0] || busy[1]) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("idle_within_bound", 0, {31'd0, busy[0] || busy[1]}, 0);
        for (int l = 0; l < 2; l++) begin
            checkOutput("done_seen", l, {31'd0, pending[l]}, 0);
            checkOutput("words_left", l, qSize(l), 0);
        end
    endtask

    task automatic waitBothValid();
        int n = 0;
        while (!(outValid[0] && outValid[1]) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("valid_within_bound", 0, {31'd0, outValid[0] && outValid[1]}, 1);
    endtask

    task automatic checkResetState();
        for (int l = 0; l < 2; l++) begin
            checkOutput("rst_busy", l, {31'd0, busy[l]}, 0);
            checkOutput("rst_done", l, {31'd0, done[l]}, 0);
            checkOutput("rst_valid", l, {31'd0, outValid[l]}, 0);
            checkOutput("rst_last", l, {31'd0, outLast[l]}, 0);
            checkOutput("rst_data", l, {16'd0, outData[l]}, 0);
            checkOutput("rst_addr", l, {16'd0, memAddr[l]}, 0);
            checkOutput("rst_read_en", l, {30'd0, memReadEn[l]}, 0);
        end
    endtask

    task automatic clearModel();
        for (int l = 0; l < 2; l++) begin
            qClear(l);
            pending[l] = 1'b0;
            doneDue[l] = 0;
        end
    endtask

    // Monitor: compares reads, delivered words and done pulses against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                prevValid[l] = 1'b0;
                prevDone[l]  = 1'b0;
            end
            prevReady = 1'b0;
            prevAbort = 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                expItem_t e;
                checkOutput("read_en_code", l,
                            {31'd0, (memReadEn[l] == 2'b00) || (memReadEn[l] == 2'b10)}, 1);
                if (memReadEn[l] == 2'b10) begin
                    issueCycle[l] = cycle;
                    checkOutput("read_in_hold", l, {31'd0, outValid[l]}, 0);
                    checkOutput("words_pending_at_read", l, {31'd0, qSize(l) > 0}, 1);
                    if (qSize(l) > 0) begin
                        e = qFront(l);
                        checkOutput("read_addr", l, {16'd0, memAddr[l]}, {16'd0, e.addr});
                    end
                end
                if (outValid[l] && !prevValid[l]) begin
                    checkOutput("valid_latency", l, cycle - issueCycle[l], latOf(l) + 1);
                end
                if (!outValid[l]) begin
                    checkOutput("last_without_valid", l, {31'd0, outLast[l]}, 0);
                end
                if (prevValid[l] && !prevReady && !prevAbort && outValid[l]) begin
                    checkOutput("data_stable", l, {16'd0, outData[l]}, {16'd0, prevData[l]});
                    checkOutput("last_stable", l, {31'd0, outLast[l]}, {31'd0, prevLast[l]});
                end
                if (outValid[l] && outReady && !abort) begin
                    checkOutput("words_pending_at_handshake", l, {31'd0, qSize(l) > 0}, 1);
                    if (qSize(l) > 0) begin
                        e = qPop(l);
                        checkOutput("out_data", l, {16'd0, outData[l]}, {16'd0, e.data});
                        checkOutput("out_last", l, {31'd0, outLast[l]}, {31'd0, e.last});
                        if (e.last) doneDue[l] = cycle + 1;
                    end
                end
                if (done[l]) begin
                    checkOutput("done_expected", l, {31'd0, pending[l]}, 1);
                    checkOutput("done_after_all_words", l, qSize(l), 0);
                    checkOutput("done_one_cycle", l, {31'd0, prevDone[l]}, 0);
                    if (doneDue[l] != 0) checkOutput("done_timing", l, cycle, doneDue[l]);
                    pending[l] = 1'b0;
                    doneDue[l] = 0;
                end
                if (abort && busy[l]) begin
                    qClear(l);
                    pending[l] = 1'b0;
                    doneDue[l] = 0;
                end
                prevValid[l] = outValid[l];
                prevData[l]  = outData[l];
                prevLast[l]  = outLast[l];
                prevDone[l]  = done[l];
            end
            prevReady = outReady;
            prevAbort = abort;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        baseAddr  = '0;
        wordCount = '0;
        for (int l = 0; l < 2; l++) begin
            pending[l]    = 1'b0;
            doneDue[l]    = 0;
            issueCycle[l] = 0;
            prevValid[l]  = 1'b0;
            prevDone[l]   = 1'b0;
            prevLast[l]   = 1'b0;
            prevData[l]   = '0;
        end
        for (int a = 0; a < 65536; a++) begin
            mem[a] = (a < 16) ? DW'(a * 10) : DW'($urandom);
        end

        repeat (3) @(posedge clk);
        #1;
        checkResetState();

        // Start held across release: ignored on the first edge, taken on the second.
        rst_n = 1'b1;
        pushDump(16'd100, 16'd2);
        start     = 1'b1;
        baseAddr  = 16'd100;
        wordCount = 16'd2;
        @(posedge clk); #1;
        for (int l = 0; l < 2; l++) checkOutput("start_ignored_first_edge", l, {31'd0, busy[l]}, 0);
        @(posedge clk); #1;
        for (int l = 0; l < 2; l++) checkOutput("start_taken_second_edge", l, {31'd0, busy[l]}, 1);
        start = 1'b0;
        waitIdle();

        readyPct = 100;
        applyStimulus(16'd1, 16'd4);
        waitIdle();

        applyStimulus(16'd5, 16'd0);
        waitIdle();

        // Each word is held unaccepted for five cycles before a single handshake.
        readyPct = 0;
        applyStimulus(16'd1, 16'd4);
        for (int w = 0; w < 4; w++) begin
            waitBothValid();
            repeat (5) @(posedge clk);
            #1;
            readyPct = 100;
            @(posedge clk); #1;
            readyPct = 0;
        end
        readyPct = 100;
        waitIdle();

        applyStimulus(16'hFFFF, 16'd2);
        waitIdle();

        applyStimulus(16'd40, 16'd5);
        n = 0;
        while (!(memReadEn[1] == 2'b10 && memAddr[1] == 16'd42) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("third_read_seen", 1, {16'd0, memAddr[1]}, 32'd42);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int l = 0; l < 2; l++) begin
            checkOutput("abort_idle", l, {31'd0, busy[l]}, 0);
            checkOutput("abort_no_valid", l, {31'd0, outValid[l]}, 0);
        end
        waitIdle();
        applyStimulus(16'd40, 16'd5);
        waitIdle();

        readyPct = 0;
        applyStimulus(16'd200, 16'd3);
        waitBothValid();
        rst_n = 1'b0;
        clearModel();
        #1;
        checkResetState();
        @(posedge clk); #1;
        rst_n = 1'b1;
        readyPct = 100;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(16'd300, 16'd3);
        waitIdle();

        for (int i = 0; i < 16; i++) begin
            logic [AW-1:0] b;
            int c;
            b = ($urandom_range(3) == 0) ? (16'hFFFF - AW'($urandom_range(3))) : AW'($urandom);
            c = $urandom_range(6);
            readyPct = 30 + int'($urandom_range(70));
            applyStimulus(b, AW'(c));
            if ($urandom_range(3) == 0) begin
                repeat ($urandom_range(12)) @(posedge clk);
                #1;
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
            end
            waitIdle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
